// File: rtl/intdiv_sd2conv.sv
// Back end of the SD2 array divider: on-the-fly conversion of signed-digit quotient and
// remainder to two's complement, remainder sign correction, and a valid/ready output stage.
module intdiv_sd2conv #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] q_sd,
    input  logic [2*N-1:0] r_sd,
    input  logic           x_sign,
    input  logic [N-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   q,
    output logic [N-1:0]   r,
    output logic           ovf
);

    localparam int unsigned W  = N + 2;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CONV, CORR, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  qsh;
    logic [2*N-1:0]  rsh;
    logic            xs;
    logic [N-1:0]    yv;
    logic [W-1:0]    qa;
    logic [W-1:0]    qm;
    logic [W-1:0]    ra;
    logic [W-1:0]    rm;

    logic [W-1:0]    qa_nx;
    logic [W-1:0]    qm_nx;
    logic [W-1:0]    ra_nx;
    logic [W-1:0]    rm_nx;
    logic [W-1:0]    yx;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;
    logic            ovf_c;

    // One on-the-fly step: digit 11 = -1, 00 = 0, 01/10 = +1. Returns {A', AM'}.
    function automatic logic [2*W-1:0] otf(input logic [W-1:0] a,
                                           input logic [W-1:0] am,
                                           input logic [1:0]   d);
        logic         pos;
        logic         neg;
        logic [W-1:0] na;
        logic [W-1:0] nam;
        pos = d[1] ^ d[0];
        neg = d[1] & d[0];
        na  = neg ? W'({am, 1'b1}) : W'({a, pos});
        nam = pos ? W'({a, 1'b0})  : W'({am, ~neg});
        return {na, nam};
    endfunction

    always_comb begin
        {qa_nx, qm_nx} = otf(qa, qm, qsh[2*N-1 -: 2]);
        {ra_nx, rm_nx} = otf(ra, rm, rsh[2*N-1 -: 2]);
        yx    = {{2{yv[N-1]}}, yv};
        q_fix = qa;
        r_fix = ra;
        // A nonzero remainder must carry the dividend's sign
        if ((ra != '0) && (ra[W-1] != xs)) begin
            if (ra[W-1] == yv[N-1]) begin
                r_fix = ra - yx;
                q_fix = qa + W'(1);
            end else begin
                r_fix = ra + yx;
                q_fix = qm;
            end
        end
        ovf_c = (|q_fix[W-1:N-1]) & ~(&q_fix[W-1:N-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            qsh       <= '0;
            rsh       <= '0;
            xs        <= 1'b0;
            yv        <= '0;
            qa        <= '0;
            qm        <= '0;
            ra        <= '0;
            rm        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        qsh      <= q_sd;
                        rsh      <= r_sd;
                        xs       <= x_sign;
                        yv       <= y;
                        cnt      <= CW'(N - 1);
                        // Minus forms start at -1 so AM = A - 1 holds from the first digit
                        qa       <= '0;
                        qm       <= '1;
                        ra       <= '0;
                        rm       <= '1;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    qa  <= qa_nx;
                    qm  <= qm_nx;
                    ra  <= ra_nx;
                    rm  <= rm_nx;
                    qsh <= qsh << 2;
                    rsh <= rsh << 2;
                    if (cnt == '0) begin
                        state <= CORR;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                CORR: begin
                    qa        <= q_fix;
                    ra        <= r_fix;
                    q         <= q_fix[N-1:0];
                    r         <= r_fix[N-1:0];
                    ovf       <= ovf_c;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intdiv_sd2conv.sv
// Directed bench for intdiv_sd2conv: scoreboarded jobs, latency, output hold and reset abort.
module tb_intdiv_sd2conv;

    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] q_sd;
    logic [2*N-1:0] r_sd;
    logic           x_sign;
    logic [N-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   q;
    logic [N-1:0]   r;
    logic           ovf;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    intdiv_sd2conv #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .q_sd     (q_sd),
        .r_sd     (r_sd),
        .x_sign   (x_sign),
        .y        (y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q        (q),
        .r        (r),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] enc(input int d);
        return (d < 0) ? 2'b11 : ((d > 0) ? 2'b01 : 2'b00);
    endfunction

    // Digits listed MSB..LSB
    function automatic logic [7:0] sd(input int d3, input int d2, input int d1, input int d0);
        return {enc(d3), enc(d2), enc(d1), enc(d0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input string tag, input logic [7:0] qsd, input logic [7:0] rsd,
                        input logic xsg, input logic [3:0] yy,
                        input logic [3:0] eq, input logic [3:0] er, input logic eo,
                        input int hold);
        int   lat;
        exp_t e;
        exp_t none;
        none = '{q: 'x, r: 'x, ovf: 1'bx};
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        q_sd     = qsd;
        r_sd     = rsd;
        x_sign   = xsg;
        y        = yy;
        in_valid = 1'b1;
        sb.push_back('{q: eq, r: er, ovf: eo});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        q_sd     = 8'hA5;
        r_sd     = 8'h5A;
        lat      = 0;
        check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(N + 1));
        check({tag, ".sb_depth"}, 32'(sb.size()), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : none;
        check({tag, ".q"}, 32'(q), 32'(e.q));
        check({tag, ".r"}, 32'(r), 32'(e.r));
        check({tag, ".ovf"}, 32'(ovf), 32'(e.ovf));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            q_sd     = sd(1, 1, 1, 1);
            r_sd     = sd(0, 0, 1, 1);
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_q"}, 32'(q), 32'(e.q));
            check({tag, ".hold_r"}, 32'(r), 32'(e.r));
            check({tag, ".hold_ovf"}, 32'(ovf), 32'(e.ovf));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".released_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".released_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_sd      = '0;
        r_sd      = '0;
        x_sign    = 1'b0;
        y         = '0;
        #12;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.q", 32'(q), 32'd0);
        check("reset.r", 32'(r), 32'd0);
        check("reset.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // x=7,y=2 with 2'b10 used as +1
        send("x7y2", 8'b00_10_00_11, sd(0, 0, 0, 1), 1'b0, 4'd2, 4'd3, 4'd1, 1'b0, 0);
        send("x7y2_radd", sd(0, 1, 0, 0), sd(0, 0, 0, -1), 1'b0, 4'd2, 4'd3, 4'd1, 1'b0, 0);
        send("xm7y2_rsub", sd(0, -1, 0, 0), sd(0, 0, 0, 1), 1'b1, 4'd2, 4'hD, 4'hF, 1'b0, 0);
        send("xm8ym1_ovf", sd(1, 0, 0, 0), 8'h00, 1'b1, 4'hF, 4'h8, 4'h0, 1'b1, 3);
        send("x7ym2_rsub", sd(0, -1, 0, 0), sd(0, 0, 0, -1), 1'b0, 4'hE, 4'hD, 4'h1, 1'b0, 0);
        send("xm7ym2_radd", sd(0, 1, 0, 0), sd(0, 0, 0, 1), 1'b1, 4'hE, 4'h3, 4'hF, 1'b0, 0);
        send("xm7y2_nocorr", sd(0, -1, 0, 1), sd(0, 0, 0, -1), 1'b1, 4'd2, 4'hD, 4'hF, 1'b0, 0);
        send("xm8y1_minq", sd(-1, 0, 0, 0), 8'h00, 1'b1, 4'd1, 4'h8, 4'h0, 1'b0, 1);

        // Reset during the second conversion cycle aborts the job
        @(negedge clk);
        q_sd     = sd(0, 1, 0, -1);
        r_sd     = sd(0, 0, 0, 1);
        x_sign   = 1'b0;
        y        = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("abort.no_output", 32'(out_valid), 32'd0);
        send("after_abort", sd(0, 1, 0, -1), sd(0, 0, 0, 1), 1'b0, 4'd2, 4'd3, 4'd1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
